k_fifo_2deep_ctl: RTL
=====================

Name: k_fifo_2deep_ctl

Overview:
Two-entry first-word-fall-through FIFO. It provides the control end for the team's 2-deep dual-port RAM: write/read pointers, occupancy tracking and valid/ready handshakes on both sides. Storage is a 2-entry register array inside this block, with a registered write and a combinational read, the same as the RAM. It sits between pipeline stages as a small elastic buffer that decouples back-pressure.

Parameters:
data_size, 8, width of each data word in bits
addr_size, 2, number of entries; fixed at 2, and any other value is unsupported (1-bit pointers)

Ports:
clk  input  1  rising-edge clock for all state
rst  input  1  synchronous reset, active-high; sampled on posedge clk
flush  input  1  synchronous clear of contents; pointers and count go to 0
wr_valid  input  1  upstream presents wr_data
wr_ready  output  1  FIFO can accept; equals (count != 2)
wr_data  input  data_size  write word
rd_valid  output  1  head entry available; equals (count != 0)
rd_ready  input  1  downstream accepts head
rd_data  output  data_size  head word, combinational from mem[rptr]
count  output  2  occupancy, 0..2
ovf_err  output  1  sticky: wr_valid asserted while full (write dropped)
udf_err  output  1  sticky: rd_ready asserted while empty

Behaviour:
- Reset: rst=1 at posedge gives wptr=0, rptr=0, count=0, ovf_err=0, udf_err=0.
  - After reset: wr_ready=1, rd_valid=0.
  - Memory contents are not reset; rd_data is don't-care while rd_valid=0.
- Priority: rst > flush > normal operation.
  - flush clears wptr, rptr and count.
  - flush leaves the sticky error flags unchanged.
  - flush blocks any push or pop in the same cycle.
- push = wr_valid & wr_ready; pop = rd_valid & rd_ready. Both are evaluated from pre-edge state.
- On push: mem[wptr] <= wr_data; wptr <= ~wptr.
- On pop: rptr <= ~rptr. Pointers wrap 1 to 0.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on push and pop together, or neither.
- Simultaneous push and pop:
  - count=1: legal; the new word lands in the other slot and becomes the head next cycle.
  - count=2: not possible, because wr_ready=0.
  - count=0: pop is not possible (rd_valid=0), so this is a push only.
- Latency:
  - A word written at edge N appears on rd_data with rd_valid=1 after edge N (first-word fall-through, zero bubble).
  - Occupancy is visible on count the cycle after the edge.
- Full (count=2): wr_ready=0.
  - wr_valid=1 sets ovf_err at the next edge.
  - No state change otherwise.
- Empty (count=0): rd_valid=0.
  - rd_ready=1 sets udf_err at the next edge.
  - Pointers do not move.
- Error flags clear only on rst.
- wr_ready and rd_valid are pure functions of registered count; there is no combinational path from rd_ready to wr_ready.
  - Consequence: a full FIFO accepts the next write one cycle after a pop.
- Throughput: a sustained 1 word/cycle is achievable when count=1 with both sides active.
- Reset mid-operation: all in-flight contents are discarded; the first post-reset write lands in slot 0.

Test Plan:
- Reset, then check: count=0, wr_ready=1, rd_valid=0, ovf_err=0, udf_err=0.
- Push 0xA5 then 0x3C, no reads -> count=2, wr_ready=0, rd_data=0xA5; pop -> rd_data=0x3C, count=1; pop -> rd_valid=0.
- Fill to 2 (0x11, 0x22), hold wr_valid=1 with 0x33 one cycle -> ovf_err=1, count=2; pops return 0x11, 0x22 and 0x33 never appears.
- count=1 (head 0x01), then 4 cycles with push and pop together (0x02..0x05) -> count stays 1; rd_data sequence is 0x01, 0x02, 0x03, 0x04, 0x05 (pointer wrap exercised).
- Empty FIFO, rd_ready=1 -> udf_err=1, rptr unchanged; a later push of 0x77 reads back 0x77.
- Fill to 2, assert flush with wr_valid=1 and data 0x99 -> count=0 and rd_valid=0 next cycle, 0x99 not stored, error flags retained.
- Then rst=1 with count=1 -> all outputs at reset values, and the next push of 0x5A is read back as 0x5A.

Source files
------------

// File: rtl/k_fifo_2deep_ctl.sv
// Two-entry first-word-fall-through FIFO: pointers, occupancy, handshakes and
// a 2-word register array (registered write, combinational read).
module k_fifo_2deep_ctl #(
   parameter int unsigned data_size = 8,
   parameter int unsigned addr_size = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [data_size-1:0] wr_data,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic [data_size-1:0] rd_data,
   output logic [1:0]           count,
   output logic                 ovf_err,
   output logic                 udf_err
);

   localparam int unsigned CNT_W = 2;
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_EMPTY = CNT_W'(0);

   // Storage: depth follows addr_size, addressed by 1-bit pointers.
   logic [data_size-1:0] r_mem [addr_size];

   logic             r_wptr;
   logic             r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf_err;
   logic             r_udf_err;

   logic             w_push;
   logic             w_pop;
   logic             w_ovf_hit;
   logic             w_udf_hit;
   logic             w_wptr_nxt;
   logic             w_rptr_nxt;
   logic [CNT_W-1:0] w_count_nxt;

   // Handshake qualifiers, all derived from registered occupancy.
   always_comb begin
      wr_ready  = (r_count != CNT_FULL);
      rd_valid  = (r_count != CNT_EMPTY);
      w_push    = wr_valid & wr_ready;
      w_pop     = rd_valid & rd_ready;
      w_ovf_hit = wr_valid & ~wr_ready;
      w_udf_hit = rd_ready & ~rd_valid;
   end

   // Next pointer and occupancy; flush discards contents and blocks push/pop.
   always_comb begin
      w_wptr_nxt  = r_wptr;
      w_rptr_nxt  = r_rptr;
      w_count_nxt = r_count;
      if (flush) begin
         w_wptr_nxt  = 1'b0;
         w_rptr_nxt  = 1'b0;
         w_count_nxt = CNT_EMPTY;
      end else begin
         if (w_push) w_wptr_nxt = ~r_wptr;
         if (w_pop)  w_rptr_nxt = ~r_rptr;
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
         endcase
      end
   end

   // Control state; sticky error flags only set in normal operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr    <= 1'b0;
         r_rptr    <= 1'b0;
         r_count   <= CNT_EMPTY;
         r_ovf_err <= 1'b0;
         r_udf_err <= 1'b0;
      end else begin
         r_wptr  <= w_wptr_nxt;
         r_rptr  <= w_rptr_nxt;
         r_count <= w_count_nxt;
         if (!flush) begin
            if (w_ovf_hit) r_ovf_err <= 1'b1;
            if (w_udf_hit) r_udf_err <= 1'b1;
         end
      end
   end

   // Data write; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (!rst && !flush && w_push) begin
         r_mem[r_wptr] <= wr_data;
      end
   end

   assign rd_data = r_mem[r_rptr];
   assign count   = r_count;
   assign ovf_err = r_ovf_err;
   assign udf_err = r_udf_err;

endmodule
